sqrt_sched: RTL
===============

SQRT_SCHED -- requirements
Module: sqrt_sched

Interface
REQ-001 The block SHALL have the following ports:
  clk  in  1  clock; all state changes on rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  req_valid  in  4  per-requester request valid; bit i belongs to requester i.
  req_operand  in  32  four 8-bit operands; requester i uses bits [8i+7:8i].
  req_ready  out  4  per-requester accept; at most one bit high in any cycle.
  rsp_valid  out  1  result available.
  rsp_id  out  2  index of the requester that owns the result.
  rsp_root  out  4  floor(sqrt(operand)).
  rsp_rem  out  5  operand - rsp_root^2.
  rsp_ready  in  1  consumer accepts the result.
  busy  out  1  high whenever state is not IDLE.
REQ-002 The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-003 The block SHALL share one iterative 8-bit integer square-root datapath among four requesters.
REQ-004 The FSM SHALL have exactly three states: IDLE, CALC and RESP.
REQ-005 IDLE -> CALC on an accept, where an accept is req_valid[i] & req_ready[i] at a rising edge.
REQ-006 CALC -> RESP after exactly 4 CALC cycles, counted by a 2-bit iteration counter that runs 0..3.
REQ-007 RESP -> IDLE on rsp_valid & rsp_ready; otherwise the FSM SHALL remain in RESP.
REQ-008 Grant SHALL be round-robin.
  Search order: pointer, pointer+1, ... mod 4.
  Grant: first requester with req_valid high.
  req_ready[grant]=1 only while in IDLE; all req_ready bits SHALL be 0 in CALC and RESP.
REQ-009 On accept, pointer SHALL become (grant+1) mod 4; pointer SHALL be unchanged otherwise.
REQ-010 On accept, the block SHALL capture the operand and the grant index.
  Input changes after accept SHALL be ignored.
  Setup: root=0, rem=0, iteration=0.
REQ-011 Each CALC cycle SHALL process the next bit pair of the operand, MSB pair first, as follows.
  t = (rem<<2) | pair, 6 bits.
  trial = (root<<2) | 1, 5 bits.
  If t >= trial: rem = t - trial, root = (root<<1)|1.
  Otherwise: rem = t, root = root<<1.
REQ-012 Internal widths SHALL be no smaller than: rem 6 bits, root 4 bits; no intermediate value may overflow.
REQ-013 Latency: for an accept at edge k, rsp_valid SHALL be 1 from edge k+4 until the response handshake.
REQ-014 rsp_id, rsp_root and rsp_rem SHALL be valid only while rsp_valid=1 and SHALL stay stable while rsp_ready=0.
REQ-015 No new accept SHALL occur in the same cycle as the response handshake.
  The earliest next accept is the edge after return to IDLE.
  Minimum interval between accepts: 6 cycles.
REQ-016 A requester dropping req_valid before it is granted SHALL lose its request silently.
REQ-017 With no req_valid bit high in IDLE, the block SHALL remain in IDLE with all req_ready bits 0.

Reset
REQ-018 While rst_n=0 at a rising edge, the block SHALL set:
  state=IDLE, pointer=0, iteration=0, root=0, rem=0, captured id=0.
  Outputs: rsp_valid=0, rsp_id=0, rsp_root=0, rsp_rem=0, busy=0.
REQ-019 Reset in CALC or RESP SHALL abandon the operation with no response; the first cycle after reset release SHALL be IDLE.

Verification
REQ-020 Single request: req_valid=0001, operand0=200 -> accept at edge k; at edge k+4 rsp_valid=1, rsp_id=0, rsp_root=14, rsp_rem=4.
REQ-021 Extremes, one request at a time from requester 2:
  operand 255 -> root 15, rem 30.
  operand 0 -> root 0, rem 0.
  operand 1 -> root 1, rem 0.
REQ-022 Contention: after reset, req_valid=1111 held, operands 1, 4, 9, 16, rsp_ready=1.
  Required grants: 0, 1, 2, 3.
  Required results: (id0, 1, 0), (id1, 2, 0), (id2, 3, 0), (id3, 4, 0).
  Accepts SHALL occur 6 cycles apart.
REQ-023 Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid and the rsp_* fields stay constant, req_ready=0000, busy=1; rsp_ready=1 -> handshake, IDLE on the next edge.
REQ-024 Reset mid-CALC: rst_n=0 during iteration 2 -> rsp_valid=0 with no response. Then req_valid=0101 -> requester 0 granted first (pointer=0), requester 2 next.
REQ-025 Fairness: req_valid=1001 held -> grant order 0, 3, 0, 3; requester 0 is never granted twice in a row.

Source files
------------

// File: rtl/sqrt_sched.sv
// sqrt_sched: four requesters share one iterative 8-bit integer square-root unit.
// A round-robin arbiter accepts one operand in IDLE. Four CALC cycles then resolve
// one result bit each. The result is held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid[3:0]    per-requester request
//   req_operand[31:0] operand of requester i in bits [8i+7:8i]
//   req_ready[3:0]    one-hot accept, asserted only in IDLE
//   rsp_valid         result available (RESP)
//   rsp_id[1:0]       owning requester
//   rsp_root[3:0]     floor(sqrt(operand))
//   rsp_rem[4:0]      operand - root^2
//   rsp_ready         consumer accepts the result
//   busy              state is not IDLE
module sqrt_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_operand,
    output logic [3:0]  req_ready,
    output logic        rsp_valid,
    output logic [1:0]  rsp_id,
    output logic [3:0]  rsp_root,
    output logic [4:0]  rsp_rem,
    input  logic        rsp_ready,
    output logic        busy
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned ROOT_W = 4;
    localparam int unsigned REM_W  = 6;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned IT_W   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   ptr_q,   ptr_d;
    logic [IT_W-1:0]   iter_q,  iter_d;
    logic [ROOT_W-1:0] root_q,  root_d;
    logic [REM_W-1:0]  rem_q,   rem_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic [OP_W-1:0]   op_q,    op_d;

    logic [ID_W-1:0]   grant;
    logic              grant_vld;
    logic [1:0]        pair;
    logic [REM_W-1:0]  t_val;
    logic [4:0]        trial;
    logic              fits;

    // Round-robin search starting at the pointer; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_vld && req_valid[ptr_q + ID_W'(k)]) begin
                grant     = ptr_q + ID_W'(k);
                grant_vld = 1'b1;
            end
        end
    end

    // One restoring-square-root step; iteration 0 consumes the MSB pair.
    always_comb begin
        pair  = 2'(op_q >> {~iter_q, 1'b0});
        t_val = REM_W'({rem_q, pair});
        trial = 5'({root_q, 2'b01});
        fits  = (t_val >= REM_W'(trial));
    end

    // Next-state and control.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        iter_d    = iter_q;
        root_d    = root_q;
        rem_d     = rem_q;
        id_d      = id_q;
        op_d      = op_q;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = 1'b1;
                    state_d = ST_CALC;
                    ptr_d   = grant + ID_W'(1);
                    id_d    = grant;
                    op_d    = OP_W'(req_operand >> {grant, 3'b000});
                    root_d  = '0;
                    rem_d   = '0;
                    iter_d  = '0;
                end
            end
            ST_CALC: begin
                if (fits) begin
                    rem_d  = t_val - REM_W'(trial);
                    root_d = ROOT_W'({root_q, 1'b1});
                end else begin
                    rem_d  = t_val;
                    root_d = ROOT_W'({root_q, 1'b0});
                end
                iter_d = iter_q + IT_W'(1);
                if (iter_q == IT_W'(3)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            iter_q  <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            iter_q  <= iter_d;
            root_q  <= root_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
            op_q    <= op_d;
        end
    end

    // Result fields come straight from registers and hold while in RESP.
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = id_q;
    assign rsp_root  = root_q;
    assign rsp_rem   = 5'(rem_q);

endmodule
